// File: rtl/clk_pkg.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// clk_pkg
// Shared definitions for the digital clock front end:
//   - rpt_state_t  : per-button auto-repeat FSM state encoding
//   - timing       : board clock rate and button timing in milliseconds
//   - button index : bit position of each board push-button on btn_* buses
//   - ms_to_cycles : converts a millisecond interval to clk cycles
// ---------------------------------------------------------------------------
package clk_pkg;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_HELD   = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_t;

  localparam int CLK_HZ      = 50000000;
  localparam int DEBOUNCE_MS = 20;
  localparam int HOLD_MS     = 1000;
  localparam int REPEAT_MS   = 250;

  localparam int BTN_CLR    = 0;
  localparam int BTN_ALARM  = 1;
  localparam int BTN_TWELVE = 2;
  localparam int BTN_SHIFT  = 3;

  // Divide first so the intermediate product stays inside 32 bits.
  function automatic int ms_to_cycles(input int ms);
    return (CLK_HZ / 1000) * ms;
  endfunction

endpackage

// File: rtl/btn_channel.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// btn_channel
// One push-button channel: two-flop synchroniser, counter debounce and an
// auto-repeat FSM (IDLE -> HELD -> REPEAT).
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset, clears every flop
//   btn_raw      raw button pin, active-high, asynchronous to clk
//   repeat_en    auto-repeat enable for this channel (clk domain)
//   btn_level    debounced button state
//   btn_press    one-cycle strobe when btn_level rises
//   btn_release  one-cycle strobe when btn_level falls
//   btn_repeat   one-cycle auto-repeat strobe while held
// ---------------------------------------------------------------------------
module btn_channel
  import clk_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 12500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  input  logic repeat_en,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_repeat
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int RP_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int RP_W   = $clog2(RP_MAX);

  localparam logic [DB_W-1:0] DB_TC   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RP_W-1:0] HOLD_TC = RP_W'(HOLD_CYCLES - 1);
  localparam logic [RP_W-1:0] REP_TC  = RP_W'(REPEAT_CYCLES - 1);

  logic            sync_p0;
  logic            sync_p1;
  logic [DB_W-1:0] db_cnt_p2;
  logic            level_p2;
  logic            press_p2;
  logic            release_p2;
  logic            flip;
  logic            rise;
  logic            fall;

  rpt_state_t      state_q;
  rpt_state_t      state_d;
  logic [RP_W-1:0] rp_cnt_q;
  logic [RP_W-1:0] rp_cnt_d;
  logic            repeat_q;
  logic            repeat_d;

  // ---- stage p0/p1: two-flop synchroniser --------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
    end
  end

  // ---- stage p2: debounce counter and edge strobes -----------------------
  // flip is the cycle on which the debounced level changes; rise/fall feed
  // both the registered strobes and the repeat FSM so that the FSM moves on
  // the same edge the press/release strobes appear.
  assign flip = (sync_p1 != level_p2) && (db_cnt_p2 == DB_TC);
  assign rise = flip & ~level_p2;
  assign fall = flip &  level_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt_p2  <= '0;
      level_p2   <= 1'b0;
      press_p2   <= 1'b0;
      release_p2 <= 1'b0;
    end else begin
      press_p2   <= rise;
      release_p2 <= fall;
      if (sync_p1 == level_p2) begin
        db_cnt_p2 <= '0;
      end else if (flip) begin
        db_cnt_p2 <= '0;
        level_p2  <= ~level_p2;
      end else begin
        db_cnt_p2 <= db_cnt_p2 + 1'b1;
      end
    end
  end

  // ---- repeat FSM: state register ----------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RPT_IDLE;
      rp_cnt_q <= '0;
      repeat_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rp_cnt_q <= rp_cnt_d;
      repeat_q <= repeat_d;
    end
  end

  // ---- repeat FSM: next state --------------------------------------------
  // A release overrides everything, including a repeat that falls due on
  // the same cycle.
  always_comb begin
    state_d  = state_q;
    rp_cnt_d = rp_cnt_q;
    repeat_d = 1'b0;
    if (fall) begin
      state_d  = RPT_IDLE;
      rp_cnt_d = '0;
    end else begin
      unique case (state_q)
        RPT_IDLE: begin
          if (rise) begin
            state_d  = RPT_HELD;
            rp_cnt_d = '0;
          end
        end
        RPT_HELD: begin
          if (!repeat_en) begin
            rp_cnt_d = '0;
          end else if (rp_cnt_q == HOLD_TC) begin
            repeat_d = 1'b1;
            rp_cnt_d = '0;
            state_d  = RPT_REPEAT;
          end else begin
            rp_cnt_d = rp_cnt_q + 1'b1;
          end
        end
        RPT_REPEAT: begin
          if (!repeat_en) begin
            state_d  = RPT_HELD;
            rp_cnt_d = '0;
          end else if (rp_cnt_q == REP_TC) begin
            repeat_d = 1'b1;
            rp_cnt_d = '0;
          end else begin
            rp_cnt_d = rp_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d  = RPT_IDLE;
          rp_cnt_d = '0;
        end
      endcase
    end
  end

  assign btn_level   = level_p2;
  assign btn_press   = press_p2;
  assign btn_release = release_p2;
  assign btn_repeat  = repeat_q;

endmodule

// File: rtl/btn_conditioner.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// btn_conditioner
// Conditions the board push-buttons (clear, alarm-set, 12/24, time-set
// shift) into synchronised, debounced, single-cycle strobes with optional
// auto-repeat, all in the clk domain.
//
// Ports
//   clk          system clock (50 MHz)
//   rst_n        asynchronous active-low reset
//   btn_raw      raw button pins, active-high, asynchronous
//   repeat_en    per-channel auto-repeat enable
//   btn_level    debounced button state
//   btn_press    one-cycle strobe on a debounced 0->1 transition
//   btn_release  one-cycle strobe on a debounced 1->0 transition
//   btn_repeat   one-cycle auto-repeat strobe
//   btn_event    btn_press | btn_repeat, the clock core's increment strobe
// ---------------------------------------------------------------------------
module btn_conditioner
  import clk_pkg::*;
#(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = ms_to_cycles(DEBOUNCE_MS),
  parameter int HOLD_CYCLES     = ms_to_cycles(HOLD_MS),
  parameter int REPEAT_CYCLES   = ms_to_cycles(REPEAT_MS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [N_BTN-1:0] repeat_en,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat,
  output logic [N_BTN-1:0] btn_event
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_raw     (btn_raw[i]),
      .repeat_en   (repeat_en[i]),
      .btn_level   (btn_level[i]),
      .btn_press   (btn_press[i]),
      .btn_release (btn_release[i]),
      .btn_repeat  (btn_repeat[i])
    );

    assign btn_event[i] = btn_press[i] | btn_repeat[i];
  end

endmodule

// File: tb/tb_btn_conditioner.sv
`timescale 1ns/1ps
module tb_btn_conditioner;
  import clk_pkg::*;

  localparam int K_PRESS   = 0;
  localparam int K_RELEASE = 1;
  localparam int K_REPEAT  = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn_raw;
  logic [3:0] repeat_en;
  logic [3:0] btn_level;
  logic [3:0] btn_press;
  logic [3:0] btn_release;
  logic [3:0] btn_repeat;
  logic [3:0] btn_event;

  btn_conditioner #(
    .N_BTN           (4),
    .DEBOUNCE_CYCLES (4),
    .HOLD_CYCLES     (10),
    .REPEAT_CYCLES   (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_raw     (btn_raw),
    .repeat_en   (repeat_en),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_repeat  (btn_repeat),
    .btn_event   (btn_event)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;
    int ch;
    int cyc;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  ev_cnt[4] = '{0, 0, 0, 0};
  int  all_cnt = 0;

  function automatic string kname(input int k);
    case (k)
      K_PRESS:   return "press";
      K_RELEASE: return "release";
      default:   return "repeat";
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int k, input int ch, input int c);
    ev_t e;
    e.kind = k;
    e.ch   = ch;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: pops one expectation per observed strobe, in kind-then-channel order.
  task automatic monitor_loop();
    logic [3:0] bits;
    ev_t        e;
    forever begin
      @(negedge clk);
      if ((btn_press | btn_repeat | btn_event) != 4'd0)
        chk("event_is_press_or_repeat", int'(btn_event), int'(btn_press | btn_repeat));
      if ((btn_press | btn_release) != 4'd0)
        chk("press_release_exclusive", int'(btn_press & btn_release), 0);
      if (btn_press == 4'hF) all_cnt++;
      for (int i = 0; i < 4; i++)
        if (btn_event[i]) ev_cnt[i]++;
      for (int k = 0; k < 3; k++) begin
        bits = (k == K_PRESS) ? btn_press : (k == K_RELEASE) ? btn_release : btn_repeat;
        for (int i = 0; i < 4; i++) begin
          if (bits[i]) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL unexpected_strobe: actual %s ch%0d cycle %0d, required none",
                       kname(k), i, cyc);
            end else begin
              e = exp_q.pop_front();
              if (e.kind != k || e.ch != i || e.cyc != cyc) begin
                errors++;
                $display("FAIL strobe: actual %s ch%0d cycle %0d, required %s ch%0d cycle %0d",
                         kname(k), i, cyc, kname(e.kind), e.ch, e.cyc);
              end
            end
            chk({"level_at_", kname(k)}, int'(btn_level[i]), (k == K_RELEASE) ? 0 : 1);
          end
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int p;
    int p2;
    int s;
    int a;
    rst_n     = 1'b0;
    btn_raw   = 4'd0;
    repeat_en = 4'd0;
    fork
      monitor_loop();
    join_none
    wait_n(3);
    chk("reset_level", int'(btn_level), 0);
    chk("reset_strobes", int'({btn_press, btn_release, btn_repeat, btn_event}), 0);
    rst_n = 1'b1;
    wait_n(3);

    // clean press on channel 0, no repeat
    btn_raw[BTN_CLR] = 1'b1;
    c = cyc;
    push(K_PRESS, BTN_CLR, c + 6);
    wait_n(30);
    chk("clean_level_high", int'(btn_level[BTN_CLR]), 1);
    btn_raw[BTN_CLR] = 1'b0;
    push(K_RELEASE, BTN_CLR, cyc + 6);
    wait_n(12);

    // bounce on channel 1: runs of 1, 2, 3 cycles
    for (int r = 1; r <= 3; r++) begin
      btn_raw[BTN_ALARM] = 1'b1;
      wait_n(r);
      btn_raw[BTN_ALARM] = 1'b0;
      wait_n(r);
    end
    chk("bounce_level_low", int'(btn_level[BTN_ALARM]), 0);
    btn_raw[BTN_ALARM] = 1'b1;
    push(K_PRESS, BTN_ALARM, cyc + 6);
    wait_n(12);
    btn_raw[BTN_ALARM] = 1'b0;
    push(K_RELEASE, BTN_ALARM, cyc + 6);
    wait_n(12);

    // auto-repeat on channel 3
    repeat_en[BTN_SHIFT] = 1'b1;
    s = ev_cnt[BTN_SHIFT];
    btn_raw[BTN_SHIFT] = 1'b1;
    p = cyc + 6;
    push(K_PRESS, BTN_SHIFT, p);
    for (int j = 0; j < 5; j++) push(K_REPEAT, BTN_SHIFT, p + 10 + 3 * j);
    push(K_RELEASE, BTN_SHIFT, p + 24);
    wait_n(24);
    btn_raw[BTN_SHIFT] = 1'b0;
    wait_n(12);
    chk("repeat_event_count", ev_cnt[BTN_SHIFT] - s, 6);
    repeat_en[BTN_SHIFT] = 1'b0;

    // release on the cycle a repeat is due (channel 2)
    repeat_en[BTN_TWELVE] = 1'b1;
    btn_raw[BTN_TWELVE] = 1'b1;
    p = cyc + 6;
    push(K_PRESS, BTN_TWELVE, p);
    push(K_REPEAT, BTN_TWELVE, p + 10);
    push(K_REPEAT, BTN_TWELVE, p + 13);
    push(K_RELEASE, BTN_TWELVE, p + 16);
    wait_n(16);
    btn_raw[BTN_TWELVE] = 1'b0;
    wait_n(12);
    chk("fsm_idle_after_release", int'(dut.g_ch[2].u_ch.state_q), int'(RPT_IDLE));
    repeat_en[BTN_TWELVE] = 1'b0;

    // simultaneous press on all channels
    a = all_cnt;
    btn_raw = 4'hF;
    p = cyc + 6;
    for (int i = 0; i < 4; i++) push(K_PRESS, i, p);
    wait_n(20);
    btn_raw = 4'h0;
    p = cyc + 6;
    for (int i = 0; i < 4; i++) push(K_RELEASE, i, p);
    wait_n(12);
    chk("all_press_cycles", all_cnt - a, 1);

    // reset mid-HELD with the button still held
    repeat_en[BTN_CLR] = 1'b1;
    btn_raw[BTN_CLR] = 1'b1;
    p = cyc + 6;
    push(K_PRESS, BTN_CLR, p);
    wait_n(11);
    chk("held_level_before_reset", int'(btn_level[BTN_CLR]), 1);
    rst_n = 1'b0;
    #1;
    chk("midreset_level", int'(btn_level), 0);
    chk("midreset_strobes", int'({btn_press, btn_release, btn_repeat, btn_event}), 0);
    wait_n(2);
    rst_n = 1'b1;
    p2 = cyc + 6;
    push(K_PRESS, BTN_CLR, p2);
    push(K_REPEAT, BTN_CLR, p2 + 10);
    push(K_REPEAT, BTN_CLR, p2 + 13);
    push(K_REPEAT, BTN_CLR, p2 + 16);
    push(K_RELEASE, BTN_CLR, p2 + 18);
    wait_n(18);
    btn_raw[BTN_CLR] = 1'b0;
    wait_n(12);
    repeat_en[BTN_CLR] = 1'b0;

    chk("expected_queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
